// File: rtl/uart_tx_arbiter_if.sv
// Requester lanes and UART TX side of the packet-level TX arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = 2
);
    logic [NUM_REQ-1:0]   req_valid_i;
    logic [8*NUM_REQ-1:0] req_data_i;
    logic [NUM_REQ-1:0]   req_last_i;
    logic [NUM_REQ-1:0]   req_ready_o;
    logic [NUM_REQ-1:0]   grant_o;
    logic [IDX_WIDTH-1:0] owner_idx_o;
    logic                 abort_o;
    logic                 tx_irq_o;
    logic [7:0]           tx_data_o;
    logic                 tx_busy_i;

    modport slave (
        input  req_valid_i,
        input  req_data_i,
        input  req_last_i,
        input  tx_busy_i,
        output req_ready_o,
        output grant_o,
        output owner_idx_o,
        output abort_o,
        output tx_irq_o,
        output tx_data_o
    );

    modport master (
        output req_valid_i,
        output req_data_i,
        output req_last_i,
        output tx_busy_i,
        input  req_ready_o,
        input  grant_o,
        input  owner_idx_o,
        input  abort_o,
        input  tx_irq_o,
        input  tx_data_o
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular sharing of the UART TX byte path.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int IDX_WIDTH    = 2,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 255
) (
    input logic clk_i,
    input logic rst_i,
    uart_tx_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOCK = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [1:0]           state_q;
    logic [7:0]           burst_q;
    logic [7:0]           idle_q;
    logic                 rel_q;
    logic [NUM_REQ-1:0]   ready_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [IDX_WIDTH-1:0] owner_q;
    logic                 abort_q;
    logic                 irq_q;
    logic [7:0]           data_q;

    logic [IDX_WIDTH-1:0] pick_idx;
    logic                 pick_ok;
    logic                 own_valid;
    logic                 own_last;
    logic [7:0]           own_data;
    logic [7:0]           burst_nx;
    logic [7:0]           idle_nx;

    function automatic logic [IDX_WIDTH-1:0] wrap_add(
        input logic [IDX_WIDTH-1:0] base,
        input int                   off
    );
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_WIDTH'(s);
    endfunction

    // Search starts just after the most recent owner and wraps once.
    always_comb begin
        pick_ok  = 1'b0;
        pick_idx = owner_q;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!pick_ok && bus.req_valid_i[wrap_add(owner_q, i)]) begin
                pick_ok  = 1'b1;
                pick_idx = wrap_add(owner_q, i);
            end
        end
    end

    always_comb begin
        own_valid = bus.req_valid_i[owner_q];
        own_last  = bus.req_last_i[owner_q];
        own_data  = bus.req_data_i[{owner_q, 3'b000} +: 8];
        burst_nx  = burst_q + 8'd1;
        idle_nx   = idle_q + 8'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            burst_q <= 8'd0;
            idle_q  <= 8'd0;
            rel_q   <= 1'b0;
            ready_q <= '0;
            grant_q <= '0;
            owner_q <= IDX_WIDTH'(NUM_REQ - 1);
            abort_q <= 1'b0;
            irq_q   <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            ready_q <= '0;
            abort_q <= 1'b0;
            irq_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_ok) begin
                        grant_q <= ONE << pick_idx;
                        owner_q <= pick_idx;
                        burst_q <= 8'd0;
                        idle_q  <= 8'd0;
                        state_q <= LOCK;
                    end
                end
                LOCK: begin
                    if (own_valid) begin
                        // Stalling on a full UART never counts as idle.
                        if (!bus.tx_busy_i) begin
                            irq_q   <= 1'b1;
                            data_q  <= own_data;
                            ready_q <= grant_q;
                            burst_q <= burst_nx;
                            idle_q  <= 8'd0;
                            rel_q   <= own_last ||
                                       (burst_nx == 8'(MAX_BURST));
                            state_q <= HOLD;
                        end
                    end else if (idle_nx == 8'(IDLE_TIMEOUT)) begin
                        abort_q <= 1'b1;
                        grant_q <= '0;
                        idle_q  <= 8'd0;
                        state_q <= IDLE;
                    end else begin
                        idle_q <= idle_nx;
                    end
                end
                HOLD: begin
                    if (rel_q) begin
                        grant_q <= '0;
                        state_q <= IDLE;
                    end else begin
                        state_q <= LOCK;
                    end
                end
                default: begin
                    grant_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready_o = ready_q;
    assign bus.grant_o     = grant_q;
    assign bus.owner_idx_o = owner_q;
    assign bus.abort_o     = abort_q;
    assign bus.tx_irq_o    = irq_q;
    assign bus.tx_data_o   = data_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: directed scenarios plus randomized packet traffic.
module tb_uart_tx_arbiter;
    localparam int NR    = 4;
    localparam int IW    = 2;
    localparam int MB    = 16;
    localparam int IDLET = 8;

    typedef struct {
        int         k;
        logic [7:0] d;
        bit         first;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    uart_tx_arbiter_if #(.NUM_REQ(NR), .IDX_WIDTH(IW)) bus();

    uart_tx_arbiter #(
        .NUM_REQ     (NR),
        .IDX_WIDTH   (IW),
        .MAX_BURST   (MB),
        .IDLE_TIMEOUT(IDLET)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    always #5 clk_i = ~clk_i;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          rand_busy = 0;
    logic [NR-1:0] pend;
    logic [8:0]  q [NR][$];
    exp_t        exp_q[$];

    task automatic drive_lanes();
        logic [NR-1:0]   v;
        logic [NR-1:0]   l;
        logic [8*NR-1:0] d;
        v = '0;
        l = '0;
        d = '0;
        for (int k = 0; k < NR; k++) begin
            if (q[k].size() > 0) begin
                v[k]        = 1'b1;
                l[k]        = q[k][0][8];
                d[8*k +: 8] = q[k][0][7:0];
            end
        end
        bus.req_valid_i = v;
        bus.req_last_i  = l;
        bus.req_data_i  = d;
    endtask

    // Requesters update their lanes the cycle after a ready pulse.
    task automatic step();
        @(posedge clk_i);
        #1;
        cyc++;
        for (int k = 0; k < NR; k++)
            if (pend[k]) void'(q[k].pop_front());
        pend = bus.req_ready_o;
        drive_lanes();
        if (rand_busy) bus.tx_busy_i = ($urandom_range(0, 2) == 0);
    endtask

    task automatic do_reset();
        bus.tx_busy_i = 1'b0;
        rand_busy     = 0;
        for (int k = 0; k < NR; k++) q[k].delete();
        exp_q.delete();
        pend = '0;
        drive_lanes();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
    endtask

    // Packet-level round robin: grants start after the last owner and
    // last until end of packet or MB bytes.
    task automatic build_expect();
        logic [8:0] rem [NR][$];
        int last_k;
        last_k = NR - 1;
        for (int k = 0; k < NR; k++) rem[k] = q[k];
        exp_q.delete();
        forever begin
            int k;
            k = -1;
            for (int i = 1; i <= NR; i++) begin
                int c;
                c = (last_k + i) % NR;
                if (k < 0 && rem[c].size() > 0) k = c;
            end
            if (k < 0) break;
            for (int n = 0; n < MB; n++) begin
                logic [8:0] b;
                if (rem[k].size() == 0) break;
                b = rem[k].pop_front();
                exp_q.push_back('{k: k, d: b[7:0], first: (n == 0)});
                if (b[8]) break;
            end
            last_k = k;
        end
    endtask

    task automatic run_check(
        input  int t0,
        input  bit timed,
        input  int budget,
        output int last_t
    );
        int n;
        int prev;
        bit first_ev;
        bit ab;
        n = 0;
        prev = t0;
        first_ev = 1;
        ab = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
            if (bus.abort_o) ab = 1;
            if (bus.tx_irq_o) begin
                exp_t e;
                int   et;
                e = exp_q.pop_front();
                total++;
                if (bus.req_ready_o !== (4'(1) << e.k)) begin
                    bad++;
                    $display("FAIL ready got=%b want_idx=%0d",
                             bus.req_ready_o, e.k);
                end
                total++;
                if (bus.tx_data_o !== e.d) begin
                    bad++;
                    $display("FAIL data got=%h want=%h",
                             bus.tx_data_o, e.d);
                end
                total++;
                if (bus.owner_idx_o !== IW'(e.k)) begin
                    bad++;
                    $display("FAIL owner got=%0d want=%0d",
                             bus.owner_idx_o, e.k);
                end
                if (timed) begin
                    et = first_ev ? t0 + 2 : prev + (e.first ? 3 : 2);
                    total++;
                    if (cyc != et) begin
                        bad++;
                        $display("FAIL byte_time got=%0d want=%0d",
                                 cyc, et);
                    end
                end
                prev = cyc;
                first_ev = 0;
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        total++;
        if (ab) begin
            bad++;
            $display("FAIL no_abort got=1 want=0");
        end
        last_t = prev;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (bus.grant_o !== 4'b0 || bus.req_ready_o !== 4'b0) begin
            bad++;
            $display("FAIL rst_grant_ready got=%b/%b want=0/0",
                     bus.grant_o, bus.req_ready_o);
        end
        total++;
        if (bus.owner_idx_o !== IW'(NR - 1)) begin
            bad++;
            $display("FAIL rst_owner got=%0d want=%0d",
                     bus.owner_idx_o, NR - 1);
        end
        total++;
        if (bus.abort_o !== 1'b0 || bus.tx_irq_o !== 1'b0 ||
            bus.tx_data_o !== 8'h00) begin
            bad++;
            $display("FAIL rst_tx got=%b/%b/%h want=0/0/00",
                     bus.abort_o, bus.tx_irq_o, bus.tx_data_o);
        end
    endtask

    task automatic test_single();
        int t0;
        int lt;
        do_reset();
        q[2].push_back({1'b0, 8'h41});
        q[2].push_back({1'b0, 8'h42});
        q[2].push_back({1'b1, 8'h43});
        build_expect();
        drive_lanes();
        t0 = cyc;
        step();
        total++;
        if (bus.grant_o !== 4'b0100) begin
            bad++;
            $display("FAIL single_grant got=%b want=0100", bus.grant_o);
        end
        run_check(t0, 1, 30, lt);
        for (int i = 1; i <= 2; i++) begin
            step();
            total++;
            if (bus.grant_o !== 4'b0000) begin
                bad++;
                $display("FAIL single_release t+%0d got=%b want=0000",
                         i, bus.grant_o);
            end
        end
    endtask

    task automatic test_all_four();
        int t0;
        int lt;
        do_reset();
        for (int k = 0; k < NR; k++) begin
            q[k].push_back({1'b0, 4'(k), 4'h1});
            q[k].push_back({1'b1, 4'(k), 4'h2});
        end
        q[0].push_back({1'b0, 8'h0A});
        q[0].push_back({1'b1, 8'h0B});
        build_expect();
        drive_lanes();
        t0 = cyc;
        run_check(t0, 1, 100, lt);
    endtask

    task automatic test_burst();
        int t0;
        int lt;
        do_reset();
        for (int i = 0; i < 20; i++)
            q[1].push_back({(i == 19), 8'(8'h80 + i)});
        for (int i = 0; i < 3; i++)
            q[3].push_back({(i == 2), 8'(8'hC0 + i)});
        build_expect();
        drive_lanes();
        t0 = cyc;
        run_check(t0, 1, 200, lt);
    endtask

    task automatic test_busy();
        bit seen_irq;
        bit seen_ab;
        int tb;
        do_reset();
        bus.tx_busy_i = 1'b1;
        q[0].push_back({1'b1, 8'h5A});
        drive_lanes();
        step();
        total++;
        if (bus.grant_o !== 4'b0001) begin
            bad++;
            $display("FAIL busy_grant got=%b want=0001", bus.grant_o);
        end
        seen_irq = 0;
        seen_ab  = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (bus.tx_irq_o) seen_irq = 1;
            if (bus.abort_o) seen_ab = 1;
        end
        total++;
        if (seen_irq || seen_ab) begin
            bad++;
            $display("FAIL busy_hold irq/abort got=%b/%b want=0/0",
                     seen_irq, seen_ab);
        end
        tb = cyc;
        bus.tx_busy_i = 1'b0;
        step();
        total++;
        if (bus.tx_irq_o !== 1'b1 || bus.tx_data_o !== 8'h5A ||
            cyc != tb + 1) begin
            bad++;
            $display("FAIL busy_release irq=%b data=%h cyc=%0d want=1/5a/%0d",
                     bus.tx_irq_o, bus.tx_data_o, cyc, tb + 1);
        end
    endtask

    task automatic test_timeout();
        int t0;
        int c;
        int ca;
        int lt;
        bit early;
        do_reset();
        q[0].push_back({1'b0, 8'h33});
        q[1].push_back({1'b1, 8'h44});
        drive_lanes();
        t0 = cyc;
        c  = -1;
        for (int i = 0; i < 10 && c < 0; i++) begin
            step();
            if (bus.tx_irq_o) c = cyc;
        end
        total++;
        if (c != t0 + 2 || bus.tx_data_o !== 8'h33) begin
            bad++;
            $display("FAIL to_first cyc=%0d data=%h want=%0d/33",
                     c, bus.tx_data_o, t0 + 2);
        end
        ca = -1;
        early = 0;
        for (int i = 0; i < 20 && ca < 0; i++) begin
            step();
            if (bus.tx_irq_o) early = 1;
            if (bus.abort_o) ca = cyc;
        end
        total++;
        if (ca != c + 1 + IDLET || early) begin
            bad++;
            $display("FAIL to_abort cyc=%0d irq=%b want=%0d/0",
                     ca, early, c + 1 + IDLET);
        end
        total++;
        if (bus.grant_o !== 4'b0000) begin
            bad++;
            $display("FAIL to_release got=%b want=0000", bus.grant_o);
        end
        step();
        total++;
        if (bus.grant_o !== 4'b0010 || bus.owner_idx_o !== 2'd1) begin
            bad++;
            $display("FAIL to_next got=%b/%0d want=0010/1",
                     bus.grant_o, bus.owner_idx_o);
        end
        exp_q.delete();
        exp_q.push_back('{k: 1, d: 8'h44, first: 1'b1});
        run_check(cyc, 0, 20, lt);
    endtask

    task automatic test_reset_mid();
        int lt;
        do_reset();
        q[0].push_back({1'b1, 8'h11});
        q[2].push_back({1'b1, 8'h22});
        drive_lanes();
        step();
        total++;
        if (bus.grant_o !== 4'b0001) begin
            bad++;
            $display("FAIL rm_grant got=%b want=0001", bus.grant_o);
        end
        rst_i = 1'b1;
        step();
        total++;
        if (bus.tx_irq_o !== 1'b0 || bus.req_ready_o !== 4'b0 ||
            bus.grant_o !== 4'b0 || bus.owner_idx_o !== IW'(NR - 1) ||
            bus.tx_data_o !== 8'h00) begin
            bad++;
            $display("FAIL rm_outputs irq=%b rdy=%b gnt=%b own=%0d d=%h",
                     bus.tx_irq_o, bus.req_ready_o, bus.grant_o,
                     bus.owner_idx_o, bus.tx_data_o);
        end
        rst_i = 1'b0;
        step();
        total++;
        if (bus.grant_o !== 4'b0001) begin
            bad++;
            $display("FAIL rm_restart got=%b want=0001", bus.grant_o);
        end
        exp_q.delete();
        exp_q.push_back('{k: 0, d: 8'h11, first: 1'b1});
        exp_q.push_back('{k: 2, d: 8'h22, first: 1'b1});
        run_check(cyc, 0, 40, lt);
    endtask

    task automatic test_random();
        int lt;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int k = 0; k < NR; k++) begin
                int np;
                np = $urandom_range(0, 3);
                for (int p = 0; p < np; p++) begin
                    int len;
                    len = $urandom_range(1, 24);
                    for (int b = 0; b < len; b++)
                        q[k].push_back({(b == len - 1),
                                        8'($urandom_range(0, 255))});
                end
            end
            build_expect();
            drive_lanes();
            rand_busy = 1;
            run_check(cyc, 0, 20000, lt);
            rand_busy = 0;
            bus.tx_busy_i = 1'b0;
        end
    endtask

    initial begin
        pend = '0;
        bus.tx_busy_i = 1'b0;
        drive_lanes();
        test_reset();
        test_single();
        test_all_four();
        test_burst();
        test_busy();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
